// File: rtl/betting_round_ctrl.sv
// rtl/betting_round_ctrl.sv - one betting round: per-seat actions, bet pulses, pot accumulation and payout
// Optional feature macro: BETTING_MIN_RAISE_EN (raise increment promoted to the previous raise size)
module betting_round_ctrl #(
  parameter int NUM_PLAYERS = 4,
  parameter int MAX_STACK_W = 10,
  parameter int POT_W       = 13,
  localparam int IDX_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start_round,
  input  logic [IDX_W-1:0]               first_idx,
  input  logic [NUM_PLAYERS*MAX_STACK_W-1:0] player_stack,
  input  logic                           act_valid,
  output logic                           act_ready,
  input  logic [1:0]                     act_kind,
  input  logic [MAX_STACK_W-1:0]         act_raise,
  input  logic                           award_valid,
  input  logic [IDX_W-1:0]               award_idx,
  output logic [IDX_W-1:0]               cur_player,
  output logic [MAX_STACK_W-1:0]         bet_amount,
  output logic [NUM_PLAYERS-1:0]         make_bet,
  output logic [NUM_PLAYERS-1:0]         add_profit,
  output logic [NUM_PLAYERS-1:0]         folded,
  output logic [MAX_STACK_W-1:0]         to_call,
  output logic [POT_W-1:0]               pot,
  output logic                           busy,
  output logic                           round_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ACT, S_ISSUE, S_NEXT, S_AWARD_WAIT, S_PAY, S_DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         cur, winner, nxt_seat, lone;
  logic [POT_W-1:0]         pot_q;
  logic [MAX_STACK_W-1:0]   contrib [NUM_PLAYERS];
  logic [MAX_STACK_W-1:0]   stack_arr [NUM_PLAYERS];
  logic [MAX_STACK_W-1:0]   high_bet, amount_q, amount_w, to_call_w, raise_inc, new_contrib, room, pay_w;
  logic [MAX_STACK_W:0]     want;
  logic [POT_W:0]           pot_sum;
  logic [NUM_PLAYERS-1:0]   folded_q, acted, eligible, cur_onehot;
  logic [IDX_W:0]           n_unfolded;
  logic                     fold_q, is_fold, is_raise, unsettled, award_ok;
`ifdef BETTING_MIN_RAISE_EN
  logic [MAX_STACK_W-1:0]   last_raise;
`endif

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) stack_arr[i] = player_stack[i*MAX_STACK_W +: MAX_STACK_W];
  end

  assign cur_onehot  = {{(NUM_PLAYERS-1){1'b0}}, 1'b1} << cur;
  assign to_call_w   = high_bet - contrib[cur];
  assign new_contrib = contrib[cur] + amount_q;
  assign pot_sum     = {1'b0, pot_q} + {{(POT_W+1-MAX_STACK_W){1'b0}}, amount_q};
  assign nxt_seat    = (cur == IDX_W'(NUM_PLAYERS-1)) ? '0 : cur + 1'b1;
  assign award_ok    = award_valid && ({1'b0, award_idx} < (IDX_W+1)'(NUM_PLAYERS)) && !folded_q[award_idx];
  assign room        = {MAX_STACK_W{1'b1}} - stack_arr[winner];
  assign pay_w       = (pot_q > {{(POT_W-MAX_STACK_W){1'b0}}, room}) ? room : pot_q[MAX_STACK_W-1:0];

  // Chip amount for the offered action; every form is clamped to the acting seat's stack.
  always_comb begin
    is_fold   = (act_kind == 2'b00) || (act_kind == 2'b11);
    is_raise  = (act_kind == 2'b10) && (act_raise != '0);
    raise_inc = act_raise;
`ifdef BETTING_MIN_RAISE_EN
    if (is_raise && (act_raise < last_raise)) raise_inc = last_raise;
`endif
    want = {1'b0, to_call_w} + (is_raise ? {1'b0, raise_inc} : '0);
    if (is_fold) amount_w = '0;
    else if (want > {1'b0, stack_arr[cur]}) amount_w = stack_arr[cur];
    else amount_w = want[MAX_STACK_W-1:0];
  end

  // Round-end view: seats still in, seats still able to bet, and whether any of those owe action.
  always_comb begin
    n_unfolded = '0;
    lone       = '0;
    unsettled  = 1'b0;
    eligible   = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      eligible[i] = !folded_q[i] && (stack_arr[i] != '0);
      if (!folded_q[i]) begin
        n_unfolded = n_unfolded + (IDX_W+1)'(1);
        lone       = IDX_W'(i);
      end
      if (eligible[i] && (!acted[i] || (contrib[i] != high_bet))) unsettled = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    act_ready  = 1'b0;
    make_bet   = '0;
    add_profit = '0;
    bet_amount = '0;
    round_done = 1'b0;
    case (state)
      S_IDLE:       if (start_round) state_nxt = S_WAIT_ACT;
      S_WAIT_ACT: begin
        act_ready = 1'b1;
        if (act_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (amount_q != '0) begin
          make_bet   = cur_onehot;
          bet_amount = amount_q;
        end
        state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (n_unfolded == (IDX_W+1)'(1)) state_nxt = S_PAY;
        else if (!unsettled)             state_nxt = S_AWARD_WAIT;
        else if (eligible[nxt_seat])     state_nxt = S_WAIT_ACT;
      end
      S_AWARD_WAIT: if (award_ok) state_nxt = S_PAY;
      S_PAY: begin
        add_profit = {{(NUM_PLAYERS-1){1'b0}}, 1'b1} << winner;
        bet_amount = pay_w;
        state_nxt  = S_DONE;
      end
      S_DONE: begin
        round_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur      <= '0;
      winner   <= '0;
      pot_q    <= '0;
      high_bet <= '0;
      amount_q <= '0;
      fold_q   <= 1'b0;
      folded_q <= '0;
      acted    <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) contrib[i] <= '0;
`ifdef BETTING_MIN_RAISE_EN
      last_raise <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start_round) begin
          cur      <= first_idx;
          high_bet <= '0;
          folded_q <= '0;
          acted    <= '0;
          for (int i = 0; i < NUM_PLAYERS; i++) contrib[i] <= '0;
`ifdef BETTING_MIN_RAISE_EN
          last_raise <= '0;
`endif
        end
        S_WAIT_ACT: if (act_valid) begin
          amount_q <= amount_w;
          fold_q   <= is_fold;
        end
        S_ISSUE: begin
          contrib[cur] <= new_contrib;
          pot_q        <= pot_sum[POT_W] ? {POT_W{1'b1}} : pot_sum[POT_W-1:0];
          if (fold_q) folded_q[cur] <= 1'b1;
          // A new high bet reopens action for everyone but the raiser.
          if (new_contrib > high_bet) begin
            high_bet <= new_contrib;
            acted    <= cur_onehot;
`ifdef BETTING_MIN_RAISE_EN
            last_raise <= new_contrib - high_bet;
`endif
          end else begin
            acted <= acted | cur_onehot;
          end
        end
        S_NEXT: begin
          if (n_unfolded == (IDX_W+1)'(1)) winner <= lone;
          else if (unsettled)              cur    <= nxt_seat;
        end
        S_AWARD_WAIT: if (award_ok) winner <= award_idx;
        S_PAY:        pot_q <= pot_q - {{(POT_W-MAX_STACK_W){1'b0}}, pay_w};
        default: ;
      endcase
    end
  end

  assign cur_player = cur;
  assign folded     = folded_q;
  assign to_call    = to_call_w;
  assign pot        = pot_q;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_betting_round_ctrl.sv
// tb/tb_betting_round_ctrl.sv - directed-vector bench for betting_round_ctrl with three seats
module tb_betting_round_ctrl;
  localparam int NP = 3;
  localparam int W  = 10;
  localparam int PW = 13;
  localparam int IW = 2;
`ifdef BETTING_MIN_RAISE_EN
  localparam int MR_AMT = 20;
  localparam int MR_TC  = 10;
  localparam int MR_POT = 40;
`else
  localparam int MR_AMT = 13;
  localparam int MR_TC  = 3;
  localparam int MR_POT = 26;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_round = 1'b0;
  logic [IW-1:0] first_idx = '0;
  logic [NP*W-1:0] player_stack;
  logic act_valid = 1'b0;
  logic act_ready;
  logic [1:0] act_kind = 2'b00;
  logic [W-1:0] act_raise = '0;
  logic award_valid = 1'b0;
  logic [IW-1:0] award_idx = '0;
  logic [IW-1:0] cur_player;
  logic [W-1:0] bet_amount, to_call;
  logic [NP-1:0] make_bet, add_profit, folded;
  logic [PW-1:0] pot;
  logic busy, round_done;
  logic [NP*W-1:0] stk_init = '0;
  logic stk_load = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  betting_round_ctrl #(.NUM_PLAYERS(NP), .MAX_STACK_W(W), .POT_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .start_round(start_round), .first_idx(first_idx),
    .player_stack(player_stack), .act_valid(act_valid), .act_ready(act_ready),
    .act_kind(act_kind), .act_raise(act_raise), .award_valid(award_valid),
    .award_idx(award_idx), .cur_player(cur_player), .bet_amount(bet_amount),
    .make_bet(make_bet), .add_profit(add_profit), .folded(folded), .to_call(to_call),
    .pot(pot), .busy(busy), .round_done(round_done)
  );

  always #5 clk = ~clk;

  // Seat stacks behave like the player blocks: debit on make_bet, credit on add_profit.
  always @(posedge clk) begin
    if (stk_load) player_stack <= stk_init;
    else begin
      for (int i = 0; i < NP; i++) begin
        if (make_bet[i])        player_stack[i*W +: W] <= player_stack[i*W +: W] - bet_amount;
        else if (add_profit[i]) player_stack[i*W +: W] <= player_stack[i*W +: W] + bet_amount;
      end
    end
  end

  task automatic load_stacks(input logic [W-1:0] s0, input logic [W-1:0] s1, input logic [W-1:0] s2);
    stk_init = {s2, s1, s0};
    stk_load = 1'b1;
    @(negedge clk);
    stk_load = 1'b0;
  endtask

  task automatic start(input logic [IW-1:0] idx);
    first_idx = idx;
    start_round = 1'b1;
    @(negedge clk);
    start_round = 1'b0;
  endtask

  task automatic do_act(input logic [1:0] kind, input logic [W-1:0] raise,
                        output logic [IW-1:0] seat, output logic [W-1:0] tc,
                        output logic [NP-1:0] mb, output logic [W-1:0] amt);
    bit ok = 1'b0;
    seat = '0; tc = '0; mb = '0; amt = '0;
    for (int n = 0; n < 40; n++) begin
      if (act_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL act_ready_timeout got 0 exp 1");
    end else begin
      seat = cur_player; tc = to_call;
      act_kind = kind; act_raise = raise; act_valid = 1'b1;
      @(negedge clk);
      act_valid = 1'b0;
      mb = make_bet; amt = bet_amount;
    end
  endtask

  task automatic award(input logic [IW-1:0] idx);
    award_idx = idx;
    award_valid = 1'b1;
    @(negedge clk);
    award_valid = 1'b0;
  endtask

  task automatic wait_pay(output logic [NP-1:0] ap, output logic [W-1:0] amt,
                          output logic done, output logic [PW-1:0] pot_after);
    bit ok = 1'b0;
    ap = '0; amt = '0; done = 1'b0; pot_after = '0;
    for (int n = 0; n < 40; n++) begin
      if (add_profit != '0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL add_profit_timeout got 0 exp pulse");
    end else begin
      ap = add_profit; amt = bet_amount;
      @(negedge clk);
      done = round_done; pot_after = pot;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL rst_busy got %0d exp 0", busy); end
    vectors++; if (act_ready !== 1'b0)  begin miscompares++; $display("FAIL rst_act_ready got %0d exp 0", act_ready); end
    vectors++; if (make_bet !== '0)     begin miscompares++; $display("FAIL rst_make_bet got %b exp 0", make_bet); end
    vectors++; if (add_profit !== '0)   begin miscompares++; $display("FAIL rst_add_profit got %b exp 0", add_profit); end
    vectors++; if (pot !== '0)          begin miscompares++; $display("FAIL rst_pot got %0d exp 0", pot); end
    vectors++; if (folded !== '0)       begin miscompares++; $display("FAIL rst_folded got %b exp 0", folded); end
    vectors++; if (to_call !== '0)      begin miscompares++; $display("FAIL rst_to_call got %0d exp 0", to_call); end
    vectors++; if (round_done !== 1'b0) begin miscompares++; $display("FAIL rst_round_done got %0d exp 0", round_done); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_call;
    logic [IW-1:0] seat; logic [W-1:0] tc, amt; logic [NP-1:0] mb, ap; logic done; logic [PW-1:0] pa;
    load_stacks(100, 100, 100); start(0);
    do_act(2'b10, 10, seat, tc, mb, amt);
    vectors++; if (mb !== 3'b001 || amt !== 10) begin miscompares++; $display("FAIL call_s0 got mb=%b amt=%0d exp 001/10", mb, amt); end
    do_act(2'b01, 0, seat, tc, mb, amt);
    vectors++; if (seat !== 1 || tc !== 10)     begin miscompares++; $display("FAIL call_s1_turn got seat=%0d tc=%0d exp 1/10", seat, tc); end
    vectors++; if (mb !== 3'b010 || amt !== 10) begin miscompares++; $display("FAIL call_s1 got mb=%b amt=%0d exp 010/10", mb, amt); end
    do_act(2'b01, 0, seat, tc, mb, amt);
    vectors++; if (mb !== 3'b100 || amt !== 10) begin miscompares++; $display("FAIL call_s2 got mb=%b amt=%0d exp 100/10", mb, amt); end
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b1 || act_ready !== 1'b0 || pot !== 30) begin miscompares++; $display("FAIL call_award_wait got busy=%0d rdy=%0d pot=%0d exp 1/0/30", busy, act_ready, pot); end
    award(2); wait_pay(ap, amt, done, pa);
    vectors++; if (ap !== 3'b100 || amt !== 30) begin miscompares++; $display("FAIL call_pay got ap=%b amt=%0d exp 100/30", ap, amt); end
    vectors++; if (done !== 1'b1 || pa !== 0)   begin miscompares++; $display("FAIL call_done got done=%0d pot=%0d exp 1/0", done, pa); end
  endtask

  task automatic test_folds;
    logic [IW-1:0] seat; logic [W-1:0] tc, amt; logic [NP-1:0] mb, ap; logic done; logic [PW-1:0] pa;
    load_stacks(100, 100, 100); start(0);
    do_act(2'b10, 20, seat, tc, mb, amt);
    vectors++; if (mb !== 3'b001 || amt !== 20) begin miscompares++; $display("FAIL fold_s0 got mb=%b amt=%0d exp 001/20", mb, amt); end
    do_act(2'b00, 0, seat, tc, mb, amt);
    vectors++; if (mb !== 3'b000) begin miscompares++; $display("FAIL fold_s1_mb got %b exp 000", mb); end
    do_act(2'b11, 5, seat, tc, mb, amt);
    vectors++; if (seat !== 2 || mb !== 3'b000) begin miscompares++; $display("FAIL fold_s2 got seat=%0d mb=%b exp 2/000", seat, mb); end
    wait_pay(ap, amt, done, pa);
    vectors++; if (ap !== 3'b001 || amt !== 20) begin miscompares++; $display("FAIL fold_pay got ap=%b amt=%0d exp 001/20", ap, amt); end
    vectors++; if (folded !== 3'b110 || done !== 1'b1) begin miscompares++; $display("FAIL fold_done got folded=%b done=%0d exp 110/1", folded, done); end
  endtask

  task automatic test_allin;
    logic [IW-1:0] seat; logic [W-1:0] tc, amt; logic [NP-1:0] mb, ap; logic done; logic [PW-1:0] pa;
    load_stacks(200, 15, 200); start(0);
    do_act(2'b10, 40, seat, tc, mb, amt);
    do_act(2'b01, 0, seat, tc, mb, amt);
    vectors++; if (tc !== 40 || mb !== 3'b010 || amt !== 15) begin miscompares++; $display("FAIL allin_clamp got tc=%0d mb=%b amt=%0d exp 40/010/15", tc, mb, amt); end
    do_act(2'b10, 40, seat, tc, mb, amt);
    vectors++; if (amt !== 80) begin miscompares++; $display("FAIL allin_s2_raise got %0d exp 80", amt); end
    do_act(2'b10, 40, seat, tc, mb, amt);
    vectors++; if (seat !== 0 || tc !== 40 || amt !== 80) begin miscompares++; $display("FAIL allin_s0_reraise got seat=%0d tc=%0d amt=%0d exp 0/40/80", seat, tc, amt); end
    do_act(2'b01, 0, seat, tc, mb, amt);
    vectors++; if (seat !== 2 || tc !== 40 || amt !== 40) begin miscompares++; $display("FAIL allin_skip got seat=%0d tc=%0d amt=%0d exp 2/40/40", seat, tc, amt); end
    repeat (3) @(negedge clk);
    vectors++; if (pot !== 255 || act_ready !== 1'b0) begin miscompares++; $display("FAIL allin_pot got pot=%0d rdy=%0d exp 255/0", pot, act_ready); end
    award(1); wait_pay(ap, amt, done, pa);
    vectors++; if (ap !== 3'b010 || amt !== 255 || done !== 1'b1) begin miscompares++; $display("FAIL allin_pay got ap=%b amt=%0d done=%0d exp 010/255/1", ap, amt, done); end
  endtask

  task automatic test_reraise;
    logic [IW-1:0] seat; logic [W-1:0] tc, amt; logic [NP-1:0] mb, ap; logic done; logic [PW-1:0] pa;
    load_stacks(100, 100, 100); start(0);
    do_act(2'b10, 10, seat, tc, mb, amt);
    do_act(2'b10, 10, seat, tc, mb, amt);
    vectors++; if (amt !== 20) begin miscompares++; $display("FAIL rr_s1 got %0d exp 20", amt); end
    do_act(2'b00, 0, seat, tc, mb, amt);
    do_act(2'b01, 0, seat, tc, mb, amt);
    vectors++; if (seat !== 0 || tc !== 10 || amt !== 10) begin miscompares++; $display("FAIL rr_s0_again got seat=%0d tc=%0d amt=%0d exp 0/10/10", seat, tc, amt); end
    repeat (3) @(negedge clk);
    vectors++; if (pot !== 40) begin miscompares++; $display("FAIL rr_pot got %0d exp 40", pot); end
    award(1); wait_pay(ap, amt, done, pa);
    vectors++; if (ap !== 3'b010 || amt !== 40) begin miscompares++; $display("FAIL rr_pay got ap=%b amt=%0d exp 010/40", ap, amt); end
  endtask

  task automatic test_overflow;
    logic [IW-1:0] seat; logic [W-1:0] tc, amt; logic [NP-1:0] mb, ap; logic done; logic [PW-1:0] pa;
    load_stacks(1020, 100, 100); start(0);
    do_act(2'b10, 20, seat, tc, mb, amt);
    do_act(2'b01, 0, seat, tc, mb, amt);
    do_act(2'b01, 0, seat, tc, mb, amt);
    repeat (3) @(negedge clk);
    vectors++; if (pot !== 60) begin miscompares++; $display("FAIL ovf_pot got %0d exp 60", pot); end
    award(0); wait_pay(ap, amt, done, pa);
    vectors++; if (ap !== 3'b001 || amt !== 23) begin miscompares++; $display("FAIL ovf_pay got ap=%b amt=%0d exp 001/23", ap, amt); end
    vectors++; if (done !== 1'b1 || pa !== 37) begin miscompares++; $display("FAIL ovf_carry got done=%0d pot=%0d exp 1/37", done, pa); end
  endtask

  task automatic test_reset_mid_issue;
    logic [IW-1:0] seat; logic [W-1:0] tc, amt; logic [NP-1:0] mb;
    load_stacks(100, 100, 100); start(1);
    do_act(2'b10, 10, seat, tc, mb, amt);
    vectors++; if (seat !== 1 || mb !== 3'b010 || pot !== 37) begin miscompares++; $display("FAIL rmi_issue got seat=%0d mb=%b pot=%0d exp 1/010/37", seat, mb, pot); end
    reset_n = 1'b0;
    #1;
    vectors++; if (make_bet !== '0 || bet_amount !== '0) begin miscompares++; $display("FAIL rmi_pulse got mb=%b amt=%0d exp 0/0", make_bet, bet_amount); end
    vectors++; if (busy !== 1'b0 || pot !== '0 || cur_player !== '0) begin miscompares++; $display("FAIL rmi_state got busy=%0d pot=%0d cur=%0d exp 0/0/0", busy, pot, cur_player); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_min_raise;
    logic [IW-1:0] seat; logic [W-1:0] tc, amt; logic [NP-1:0] mb, ap; logic done; logic [PW-1:0] pa;
    load_stacks(100, 100, 100); start(0);
    do_act(2'b10, 10, seat, tc, mb, amt);
    first_idx = 2; start_round = 1'b1;
    @(negedge clk);
    start_round = 1'b0;
    do_act(2'b10, 3, seat, tc, mb, amt);
    vectors++; if (seat !== 1) begin miscompares++; $display("FAIL busy_start got seat=%0d exp 1", seat); end
    vectors++; if (amt !== MR_AMT) begin miscompares++; $display("FAIL minraise_amt got %0d exp %0d", amt, MR_AMT); end
    do_act(2'b00, 0, seat, tc, mb, amt);
    do_act(2'b01, 0, seat, tc, mb, amt);
    vectors++; if (tc !== MR_TC) begin miscompares++; $display("FAIL minraise_tc got %0d exp %0d", tc, MR_TC); end
    repeat (3) @(negedge clk);
    award(2);
    repeat (2) @(negedge clk);
    vectors++; if (add_profit !== '0 || busy !== 1'b1) begin miscompares++; $display("FAIL folded_award got ap=%b busy=%0d exp 000/1", add_profit, busy); end
    award(1); wait_pay(ap, amt, done, pa);
    vectors++; if (ap !== 3'b010 || amt !== MR_POT) begin miscompares++; $display("FAIL minraise_pay got ap=%b amt=%0d exp 010/%0d", ap, amt, MR_POT); end
  endtask

  initial begin
    test_reset;
    test_call;
    test_folds;
    test_allin;
    test_reraise;
    test_overflow;
    test_reset_mid_issue;
    test_min_raise;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
